// File: rtl/izneuron_pool_pkg.sv
// izneuron_pool_pkg: shared constants, FSM encodings and helpers for the Izhikevich pool
package izneuron_pool_pkg;
    localparam int K_140 = 140;
    localparam int K_041 = 41;
    localparam int K_5 = 5;
    localparam int A_SHIFT = 12;
    localparam logic [2:0] S_INIT = 3'd0;
    localparam logic [2:0] S_IDLE = 3'd1;
    localparam logic [2:0] S_RD = 3'd2;
    localparam logic [2:0] S_WR = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/izneuron_pool_if.sv
// izneuron_pool_if: step handshake, current fetch, probe and spike outputs of the pool
interface izneuron_pool_if import izneuron_pool_pkg::*; #(
    parameter int N_NEURON = 128,
    parameter int AW = clog2(N_NEURON),
    parameter int DW = 32
);
    logic i_step_start;
    logic o_step_busy;
    logic o_step_done;
    logic [AW-1:0] o_i_addr;
    logic signed [DW-1:0] i_i_in;
    logic [AW-1:0] i_probe_idx;
    logic signed [DW-1:0] o_v_probe;
    logic [N_NEURON-1:0] o_population;
    logic [N_NEURON-1:0] o_delayed_pop;
    logic [AW:0] o_spike_count;
    modport slave (
        input i_step_start, i_i_in, i_probe_idx,
        output o_step_busy, o_step_done, o_i_addr, o_v_probe, o_population, o_delayed_pop, o_spike_count
    );
    modport master (
        output i_step_start, i_i_in, i_probe_idx,
        input o_step_busy, o_step_done, o_i_addr, o_v_probe, o_population, o_delayed_pop, o_spike_count
    );
endinterface

// File: rtl/izneuron_pool_update.sv
// izneuron_pool_update: one combinational Euler step (dt = 1 ms) of a single Izhikevich neuron
module izneuron_pool_update import izneuron_pool_pkg::*; #(
    parameter int DW = 32,
    parameter int FRAC = 10,
    parameter int A_Q12 = 82,
    parameter int B_Q = 205,
    parameter int C_Q = -66560,
    parameter int D_Q = 2048,
    parameter int V_TH = 30720,
    parameter int V_MAX = 102400,
    parameter int HIST_W = 32
) (
    input  logic signed [DW-1:0] i_v,
    input  logic signed [DW-1:0] i_u,
    input  logic signed [DW-1:0] i_i,
    input  logic [HIST_W-1:0]    i_hist,
    output logic signed [DW-1:0] o_v,
    output logic signed [DW-1:0] o_u,
    output logic [HIST_W-1:0]    o_hist,
    output logic                 o_fired
);
    localparam int PW = 2 * DW;
    logic signed [PW-1:0] w_vv, w_q, w_bv, w_au, w_sum;
    logic signed [DW-1:0] w_v2, w_q2, w_bv2, w_diff, w_dv, w_du;
    always_comb begin
        w_vv = PW'(i_v) * PW'(i_v);
        w_v2 = DW'(w_vv >>> FRAC);
        w_q = PW'(w_v2) * PW'(K_041);
        w_q2 = DW'(w_q >>> FRAC);
        w_dv = w_q2 + DW'(K_5) * i_v + (DW'(K_140) <<< FRAC) - i_u + i_i;
        w_bv = PW'(B_Q) * PW'(i_v);
        w_bv2 = DW'(w_bv >>> FRAC);
        w_diff = w_bv2 - i_u;
        w_au = PW'(A_Q12) * PW'(w_diff);
        w_du = DW'(w_au >>> A_SHIFT);
        // v + v' is formed at double width so the ceiling clamps instead of wrapping
        w_sum = PW'(i_v) + PW'(w_dv);
        o_fired = i_v > DW'(V_TH);
        o_v = o_fired ? DW'(C_Q) : (w_sum > PW'(V_MAX) ? DW'(V_MAX) : DW'(w_sum));
        o_u = i_u + (o_fired ? DW'(D_Q) : w_du);
        o_hist = {i_hist[HIST_W-2:0], o_fired};
    end
endmodule

// File: rtl/izneuron_pool.sv
// izneuron_pool: N Izhikevich neurons time-multiplexed over one update datapath,
// state held in a single-port RAM and swept once per requested step.
module izneuron_pool import izneuron_pool_pkg::*; #(
    parameter int N_NEURON = 128,
    parameter int AW = clog2(N_NEURON),
    parameter int DW = 32,
    parameter int FRAC = 10,
    parameter int A_Q12 = 82,
    parameter int B_Q = 205,
    parameter int C_Q = -66560,
    parameter int D_Q = 2048,
    parameter int V_TH = 30720,
    parameter int V_MAX = 102400,
    parameter int HIST_W = 32,
    parameter int SPK_DELAY = 14
) (
    input logic clk,
    input logic reset,
    izneuron_pool_if.slave bus
);
    localparam int PW = 2 * DW;
    localparam int MW = 2 * DW + HIST_W;
    localparam logic signed [DW-1:0] U_INIT = DW'(PW'(B_Q) * PW'(C_Q) >>> FRAC);
    logic [2:0] r_state;
    logic [AW-1:0] r_idx;
    logic [MW-1:0] r_mem [N_NEURON];
    logic [MW-1:0] r_rd;
    logic [N_NEURON-1:0] r_fired, r_dly, r_pop, r_dpop;
    logic [AW:0] r_cnt, w_cnt;
    logic r_done;
    logic signed [DW-1:0] r_vp;
    logic signed [DW-1:0] w_v, w_u, w_vn, w_un;
    logic [HIST_W-1:0] w_hist, w_hn;
    logic w_fired, w_last, w_we;
    logic [MW-1:0] w_wd;
    always_comb begin
        w_v = r_rd[MW-1 -: DW];
        w_u = r_rd[HIST_W +: DW];
        w_hist = r_rd[HIST_W-1:0];
        w_last = r_idx == AW'(N_NEURON - 1);
        w_we = r_state == S_INIT || r_state == S_WR;
        w_wd = r_state == S_INIT ? {DW'(C_Q), U_INIT, {HIST_W{1'b0}}} : {w_vn, w_un, w_hn};
        w_cnt = '0;
        for (int k = 0; k < N_NEURON; k++) w_cnt = w_cnt + {{AW{1'b0}}, r_fired[k]};
    end
    izneuron_pool_update #(
        .DW(DW), .FRAC(FRAC), .A_Q12(A_Q12), .B_Q(B_Q), .C_Q(C_Q), .D_Q(D_Q),
        .V_TH(V_TH), .V_MAX(V_MAX), .HIST_W(HIST_W)
    ) u_upd (
        .i_v(w_v), .i_u(w_u), .i_i(bus.i_i_in), .i_hist(w_hist),
        .o_v(w_vn), .o_u(w_un), .o_hist(w_hn), .o_fired(w_fired)
    );
    // read-first single-port state RAM; contents are rebuilt by the init sweep
    always_ff @(posedge clk) begin
        if (w_we) r_mem[r_idx] <= w_wd;
        r_rd <= r_mem[r_idx];
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_INIT;
            r_idx <= '0;
            r_fired <= '0;
            r_dly <= '0;
            r_pop <= '0;
            r_dpop <= '0;
            r_cnt <= '0;
            r_done <= 1'b0;
            r_vp <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_INIT: begin
                    r_idx <= r_idx + 1'b1;
                    r_state <= w_last ? S_IDLE : S_INIT;
                end
                S_IDLE: r_state <= bus.i_step_start ? S_RD : S_IDLE;
                S_RD: r_state <= S_WR;
                S_WR: begin
                    r_fired[r_idx] <= w_fired;
                    r_dly[r_idx] <= w_hn[SPK_DELAY];
                    if (r_idx == bus.i_probe_idx) r_vp <= w_vn;
                    r_idx <= r_idx + 1'b1;
                    r_state <= w_last ? S_DONE : S_RD;
                end
                S_DONE: begin
                    r_pop <= r_fired;
                    r_dpop <= r_dly;
                    r_cnt <= w_cnt;
                    r_done <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_INIT;
            endcase
        end
    end
    assign bus.o_step_busy = r_state != S_IDLE;
    assign bus.o_step_done = r_done;
    assign bus.o_i_addr = r_idx;
    assign bus.o_v_probe = r_vp;
    assign bus.o_population = r_pop;
    assign bus.o_delayed_pop = r_dpop;
    assign bus.o_spike_count = r_cnt;
endmodule

// File: tb/tb_izneuron_pool.sv
// tb_izneuron_pool: table vectors, directed corner sequences and random steps against a behavioural pool model
module tb_izneuron_pool;
    localparam int N = 16;
    localparam int AW = 4;
    localparam int DW = 32;
    localparam int DLY = 14;
    localparam int C_Q = -66560;
    localparam int V_TH = 30720;
    localparam int V_MAX = 102400;

    typedef struct {
        int i_val;
        int vp1;
        bit fire2;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    izneuron_pool_if #(.N_NEURON(N), .AW(AW), .DW(DW)) ifc ();
    izneuron_pool #(.N_NEURON(N), .AW(AW), .DW(DW)) dut (.clk(clk), .reset(reset), .bus(ifc));

    always #5 clk = ~clk;

    int cur[N];
    always @(posedge clk) ifc.i_i_in <= cur[ifc.o_i_addr];

    int mv[N];
    int mu[N];
    logic [31:0] mh[N];
    logic [N-1:0] e_pop, e_dpop;
    int e_cnt, e_vp;
    int n_chk = 0;
    int n_fail = 0;
    int tr[5];
    vec_t tbl[7];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            mv[k] = C_Q;
            mu[k] = int'((longint'(205) * C_Q) >>> 10);
            mh[k] = '0;
        end
        e_pop = '0;
        e_dpop = '0;
        e_cnt = 0;
        e_vp = 0;
    endtask

    // one Euler step of every neuron straight from the update equations
    task automatic model_step(input int old_pr, input int pr_at, input int pr_val);
        e_cnt = 0;
        for (int k = 0; k < N; k++) begin
            int v, u, a1, a2, dv, bv, du, nv, pk;
            longint s;
            bit f;
            v = mv[k];
            u = mu[k];
            f = v > V_TH;
            a1 = int'((longint'(v) * v) >>> 10);
            a2 = int'((longint'(a1) * 41) >>> 10);
            dv = a2 + 5 * v + (140 << 10) - u + cur[k];
            s = longint'(v) + dv;
            bv = int'((longint'(205) * v) >>> 10);
            du = int'((longint'(82) * (bv - u)) >>> 12);
            nv = f ? C_Q : (s > V_MAX ? V_MAX : int'(s));
            mv[k] = nv;
            mu[k] = u + (f ? 2048 : du);
            mh[k] = {mh[k][30:0], f};
            e_pop[k] = f;
            e_dpop[k] = mh[k][DLY];
            e_cnt += int'(f);
            pk = (pr_at >= 0 && 2 * k + 2 > pr_at) ? pr_val : old_pr;
            if (pk == k) e_vp = nv;
        end
    endtask

    task automatic do_reset();
        int nb, nd;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        nb = 0;
        nd = 0;
        for (int i = 0; i < N + 4; i++) begin
            nb += int'(ifc.o_step_busy);
            nd += int'(ifc.o_step_done);
            @(negedge clk);
        end
        chk("init_busy_cycles", nb, N);
        chk("init_no_done", nd, 0);
        chk("reset_population", ifc.o_population, 0);
        chk("reset_delayed_pop", ifc.o_delayed_pop, 0);
        chk("reset_spike_count", ifc.o_spike_count, 0);
        chk("reset_v_probe", ifc.o_v_probe, 0);
    endtask

    task automatic step(input int p1, input int p2, input int pr_at, input int pr_val);
        int old_pr, lat;
        old_pr = int'(ifc.i_probe_idx);
        ifc.i_step_start = 1'b1;
        @(negedge clk);
        ifc.i_step_start = 1'b0;
        lat = 0;
        while (!ifc.o_step_done && lat < 4 * N + 8) begin
            ifc.i_step_start = (lat == p1 || lat == p2);
            if (lat == pr_at) ifc.i_probe_idx = AW'(pr_val);
            @(negedge clk);
            lat++;
        end
        ifc.i_step_start = 1'b0;
        chk("step_latency", lat, 2 * N + 1);
        model_step(old_pr, pr_at, pr_val);
        chk("population", ifc.o_population, e_pop);
        chk("delayed_pop", ifc.o_delayed_pop, e_dpop);
        chk("spike_count", ifc.o_spike_count, e_cnt);
        chk("v_probe", ifc.o_v_probe, e_vp);
        @(negedge clk);
        chk("done_single_pulse", ifc.o_step_done, 0);
    endtask

    task automatic set_all(input int val);
        for (int k = 0; k < N; k++) cur[k] = val;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int dn, nsp;
        bit seen;
        logic [N-1:0] m5;
        logic spk[100];
        tbl[0] = '{0, -69450, 1'b0};
        tbl[1] = '{10240, -59210, 1'b0};
        tbl[2] = '{20480, -48970, 1'b0};
        tbl[3] = '{-5000, -74450, 1'b0};
        tbl[4] = '{171850, 102400, 1'b1};
        tbl[5] = '{171851, 102400, 1'b1};
        tbl[6] = '{200000, 102400, 1'b1};
        ifc.i_step_start = 1'b0;
        ifc.i_probe_idx = '0;
        set_all(0);
        do_reset();

        for (int t = 0; t < 7; t++) begin
            set_all(tbl[t].i_val);
            ifc.i_probe_idx = AW'(3);
            do_reset();
            step(-1, -1, -1, 0);
            chk("tbl_first_v_probe", ifc.o_v_probe, tbl[t].vp1);
            chk("tbl_first_count", ifc.o_spike_count, 0);
            if (tbl[t].fire2) begin
                step(-1, -1, -1, 0);
                chk("tbl_cap_all_fire_count", ifc.o_spike_count, N);
                chk("tbl_cap_all_fire_pop", ifc.o_population, (longint'(1) << N) - 1);
                chk("tbl_cap_reset_v", ifc.o_v_probe, C_Q);
            end
        end

        set_all(0);
        ifc.i_probe_idx = AW'(3);
        do_reset();
        for (int s = 0; s < 200; s++) begin
            step(-1, -1, -1, 0);
            if (s < 5) tr[s] = e_vp;
            chk("quiet_population", ifc.o_population, 0);
            chk("quiet_v_below", $signed(ifc.o_v_probe) <= -60000, 1);
        end

        set_all(20480);
        ifc.i_probe_idx = AW'(0);
        do_reset();
        seen = 1'b0;
        for (int s = 0; s < 40 && !seen; s++) begin
            step(-1, -1, -1, 0);
            chk("drive_v_cap", $signed(ifc.o_v_probe) <= V_MAX, 1);
            if (ifc.o_spike_count != 0) begin
                seen = 1'b1;
                chk("drive_all_fire_count", ifc.o_spike_count, N);
                chk("drive_all_fire_pop", ifc.o_population, (longint'(1) << N) - 1);
            end
        end
        chk("drive_fired_seen", seen, 1);

        set_all(0);
        cur[5] = 10240;
        ifc.i_probe_idx = AW'(5);
        do_reset();
        m5 = '1;
        m5[5] = 1'b0;
        nsp = 0;
        for (int s = 0; s < 100; s++) begin
            step(-1, -1, -1, 0);
            spk[s] = e_pop[5];
            nsp += int'(ifc.o_population[5]);
            chk("single_others_quiet", ifc.o_population & m5, 0);
            chk("single_delayed", ifc.o_delayed_pop[5], s >= DLY ? spk[s-DLY] : 1'b0);
        end
        chk("single_spiked", nsp > 0, 1);

        for (int s = 0; s < 60; s++) begin
            for (int k = 0; k < N; k++) cur[k] = int'($urandom_range(24000, 0)) - 2000;
            ifc.i_probe_idx = AW'($urandom_range(N - 1, 0));
            step(-1, -1, -1, 0);
        end

        step(N, 2 * N, -1, 0);
        dn = 0;
        repeat (3 * N) begin
            @(negedge clk);
            dn += int'(ifc.o_step_done);
        end
        chk("ignored_starts_no_done", dn, 0);
        chk("ignored_starts_idle", ifc.o_step_busy, 0);

        ifc.i_probe_idx = AW'(2);
        step(-1, -1, 10, 9);
        step(-1, -1, 10, 1);

        set_all(0);
        ifc.i_probe_idx = AW'(3);
        do_reset();
        ifc.i_step_start = 1'b1;
        @(negedge clk);
        ifc.i_step_start = 1'b0;
        dn = 0;
        repeat (N - 1) begin
            @(negedge clk);
            dn += int'(ifc.o_step_done);
        end
        do_reset();
        chk("reset_mid_no_done", dn, 0);
        for (int s = 0; s < 5; s++) begin
            step(-1, -1, -1, 0);
            chk("reset_replay_trace", ifc.o_v_probe, tr[s]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
